// File: rtl/mqnic_tx_sched_pkg.sv
// Shared definitions for the TX scheduler request path: select-width helper,
// request-tag pack/unpack helpers and counter width constants.
package mqnic_tx_sched_pkg;

  localparam int BYTE_CNT_W        = 32;
  localparam int OUTSTANDING_W_DEF = 6;

  // Width of the scheduler-select field carried in the upper tag bits.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // {sel, tag} packing; the caller truncates to its own tag width.
  function automatic logic [31:0] tag_pack(input logic [31:0] sel, input logic [31:0] tag,
                                           input int tag_w);
    return (sel << tag_w) | tag;
  endfunction

  // Recovers the scheduler select from a packed tag.
  function automatic int tag_sel(input logic [31:0] tag, input int tag_w);
    return int'(tag >> tag_w);
  endfunction

endpackage

// File: rtl/mqnic_rr_grant.sv
// Combinational rotate-priority encoder: first requester at or after the
// pointer (wrapping) wins. Pointer is assumed to be < N.
module mqnic_rr_grant #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_idx,
  output logic          o_vld
);

  int w_j;

  // Scan N positions starting from the pointer and take the first request.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_vld && i_req[w_j]) begin
        o_vld      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = SW'(w_j);
      end
    end
  end

endmodule

// File: rtl/mqnic_tx_req_arbiter.sv
// Merges per-scheduler TX requests onto one engine port with round-robin
// arbitration gated by an outstanding-request limit, tags the scheduler
// index into the upper request-tag bits and routes statuses back.
// Optional feature macro: TX_REQ_ARB_BYTE_COUNT_EN (per-scheduler byte totals).
module mqnic_tx_req_arbiter
  import mqnic_tx_sched_pkg::*;
#(
  parameter int SCHED_COUNT        = 2,
  parameter int QUEUE_INDEX_WIDTH  = 8,
  parameter int REQ_TAG_WIDTH      = 8,
  parameter int AXIS_TX_DEST_WIDTH = 5,
  parameter int LEN_WIDTH          = 16,
  parameter int OUTSTANDING_WIDTH  = OUTSTANDING_W_DEF,
  localparam int SEL_W             = sel_w(SCHED_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      enable,
  input  logic [OUTSTANDING_WIDTH-1:0]              outstanding_limit,
  input  logic [SCHED_COUNT*QUEUE_INDEX_WIDTH-1:0]  s_axis_tx_req_queue,
  input  logic [SCHED_COUNT*REQ_TAG_WIDTH-1:0]      s_axis_tx_req_tag,
  input  logic [SCHED_COUNT*AXIS_TX_DEST_WIDTH-1:0] s_axis_tx_req_dest,
  input  logic [SCHED_COUNT-1:0]                    s_axis_tx_req_valid,
  output logic [SCHED_COUNT-1:0]                    s_axis_tx_req_ready,
  output logic [QUEUE_INDEX_WIDTH-1:0]              m_axis_tx_req_queue,
  output logic [SEL_W+REQ_TAG_WIDTH-1:0]            m_axis_tx_req_tag,
  output logic [AXIS_TX_DEST_WIDTH-1:0]             m_axis_tx_req_dest,
  output logic                                      m_axis_tx_req_valid,
  input  logic                                      m_axis_tx_req_ready,
  input  logic [LEN_WIDTH-1:0]                      s_axis_tx_req_status_len,
  input  logic [SEL_W+REQ_TAG_WIDTH-1:0]            s_axis_tx_req_status_tag,
  input  logic                                      s_axis_tx_req_status_valid,
  output logic [LEN_WIDTH-1:0]                      m_axis_tx_req_status_len,
  output logic [REQ_TAG_WIDTH-1:0]                  m_axis_tx_req_status_tag,
  output logic [SCHED_COUNT-1:0]                    m_axis_tx_req_status_valid,
  output logic [SCHED_COUNT*OUTSTANDING_WIDTH-1:0]  outstanding_count,
  output logic                                      status_error,
  output logic [SCHED_COUNT*BYTE_CNT_W-1:0]         byte_count
);

  localparam int MTW = SEL_W + REQ_TAG_WIDTH;

  logic [QUEUE_INDEX_WIDTH-1:0]  w_queue [SCHED_COUNT];
  logic [REQ_TAG_WIDTH-1:0]      w_tag   [SCHED_COUNT];
  logic [AXIS_TX_DEST_WIDTH-1:0] w_dest  [SCHED_COUNT];
  logic [SCHED_COUNT-1:0]        w_elig, w_gnt, w_st_oh, w_zdec;
  logic [SEL_W-1:0]              w_gnt_idx;
  logic                          w_gnt_vld, w_load, w_grant;
  int                            w_st_sel;

  logic [SEL_W-1:0]              r_ptr;
  logic                          r_m_valid;
  logic [QUEUE_INDEX_WIDTH-1:0]  r_m_queue;
  logic [MTW-1:0]                r_m_tag;
  logic [AXIS_TX_DEST_WIDTH-1:0] r_m_dest;
  logic [SCHED_COUNT-1:0]        r_st_valid;
  logic [LEN_WIDTH-1:0]          r_st_len;
  logic [REQ_TAG_WIDTH-1:0]      r_st_tag;
  logic                          r_err;

  // Output register accepts a new beat whenever it is empty or draining.
  assign w_load   = !r_m_valid || m_axis_tx_req_ready;
  assign w_grant  = w_load && w_gnt_vld;
  assign w_st_sel = tag_sel(32'(s_axis_tx_req_status_tag), REQ_TAG_WIDTH);

  assign s_axis_tx_req_ready = w_load ? w_gnt : '0;

  mqnic_rr_grant #(.N(SCHED_COUNT), .SW(SEL_W)) u_rr (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_vld (w_gnt_vld)
  );

  for (genvar i = 0; i < SCHED_COUNT; i++) begin : g_sched
    logic [OUTSTANDING_WIDTH-1:0] r_count;
    logic                         w_inc, w_dec;

    assign w_queue[i] = s_axis_tx_req_queue[i*QUEUE_INDEX_WIDTH +: QUEUE_INDEX_WIDTH];
    assign w_tag[i]   = s_axis_tx_req_tag[i*REQ_TAG_WIDTH +: REQ_TAG_WIDTH];
    assign w_dest[i]  = s_axis_tx_req_dest[i*AXIS_TX_DEST_WIDTH +: AXIS_TX_DEST_WIDTH];
    assign w_elig[i]  = enable && s_axis_tx_req_valid[i] && (r_count < outstanding_limit);
    assign w_inc      = w_grant && w_gnt[i];
    assign w_dec      = s_axis_tx_req_status_valid && (w_st_sel == i);
    assign w_st_oh[i] = w_dec;
    assign w_zdec[i]  = w_dec && (r_count == '0);
    assign outstanding_count[i*OUTSTANDING_WIDTH +: OUTSTANDING_WIDTH] = r_count;

    // In-flight counter: grant increments, routed status decrements; a
    // decrement at zero (stale status) is ignored.
    always_ff @(posedge clk) begin
      if (rst)         r_count <= '0;
      else if (w_zdec[i]) r_count <= r_count + OUTSTANDING_WIDTH'(w_inc);
      else             r_count <= r_count + OUTSTANDING_WIDTH'(w_inc) - OUTSTANDING_WIDTH'(w_dec);
    end

`ifdef TX_REQ_ARB_BYTE_COUNT_EN
    logic [BYTE_CNT_W-1:0] r_bytes;
    // Accumulate status lengths for every status routed to this scheduler.
    always_ff @(posedge clk) begin
      if (rst)        r_bytes <= '0;
      else if (w_dec) r_bytes <= r_bytes + BYTE_CNT_W'(s_axis_tx_req_status_len);
    end
    assign byte_count[i*BYTE_CNT_W +: BYTE_CNT_W] = r_bytes;
`else
    assign byte_count[i*BYTE_CNT_W +: BYTE_CNT_W] = '0;
`endif
  end

  // Request output register and round-robin pointer advance on each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_queue <= '0;
      r_m_tag   <= '0;
      r_m_dest  <= '0;
      r_ptr     <= '0;
    end else if (w_load) begin
      r_m_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_m_queue <= w_queue[w_gnt_idx];
        r_m_tag   <= MTW'(tag_pack(32'(w_gnt_idx), 32'(w_tag[w_gnt_idx]), REQ_TAG_WIDTH));
        r_m_dest  <= w_dest[w_gnt_idx];
        r_ptr     <= (int'(w_gnt_idx) == SCHED_COUNT - 1) ? '0 : w_gnt_idx + 1'b1;
      end
    end
  end

  // Status return: one-hot valid to the issuing scheduler, sel stripped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st_valid <= '0;
      r_st_len   <= '0;
      r_st_tag   <= '0;
    end else begin
      r_st_valid <= w_st_oh;
      r_st_len   <= s_axis_tx_req_status_len;
      r_st_tag   <= s_axis_tx_req_status_tag[REQ_TAG_WIDTH-1:0];
    end
  end

  // Sticky error: status to a nonexistent scheduler or to an idle counter.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (s_axis_tx_req_status_valid && (!(|w_st_oh) || (|w_zdec))) r_err <= 1'b1;
  end

  assign m_axis_tx_req_valid        = r_m_valid;
  assign m_axis_tx_req_queue        = r_m_queue;
  assign m_axis_tx_req_tag          = r_m_tag;
  assign m_axis_tx_req_dest         = r_m_dest;
  assign m_axis_tx_req_status_valid = r_st_valid;
  assign m_axis_tx_req_status_len   = r_st_len;
  assign m_axis_tx_req_status_tag   = r_st_tag;
  assign status_error               = r_err;

endmodule

// File: tb/tb_mqnic_tx_req_arbiter.sv
// Scoreboard bench for mqnic_tx_req_arbiter with three schedulers.
module tb_mqnic_tx_req_arbiter;

  localparam int N = 3, QW = 8, TW = 8, DW = 5, LW = 16, OW = 6, SW = 2, MTW = SW + TW;

  logic              clk, rst, enable;
  logic [OW-1:0]     limit;
  logic [N*QW-1:0]   s_queue;
  logic [N*TW-1:0]   s_tag;
  logic [N*DW-1:0]   s_dest;
  logic [N-1:0]      s_valid, s_ready;
  logic [QW-1:0]     m_queue;
  logic [MTW-1:0]    m_tag;
  logic [DW-1:0]     m_dest;
  logic              m_valid, m_ready;
  logic [LW-1:0]     st_len_i, st_len_o;
  logic [MTW-1:0]    st_tag_i;
  logic [TW-1:0]     st_tag_o;
  logic              st_valid_i;
  logic [N-1:0]      st_valid_o;
  logic [N*OW-1:0]   ocount;
  logic              serr;
  logic [N*32-1:0]   bcount;

  mqnic_tx_req_arbiter #(
    .SCHED_COUNT(N), .QUEUE_INDEX_WIDTH(QW), .REQ_TAG_WIDTH(TW),
    .AXIS_TX_DEST_WIDTH(DW), .LEN_WIDTH(LW), .OUTSTANDING_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .outstanding_limit(limit),
    .s_axis_tx_req_queue(s_queue), .s_axis_tx_req_tag(s_tag), .s_axis_tx_req_dest(s_dest),
    .s_axis_tx_req_valid(s_valid), .s_axis_tx_req_ready(s_ready),
    .m_axis_tx_req_queue(m_queue), .m_axis_tx_req_tag(m_tag), .m_axis_tx_req_dest(m_dest),
    .m_axis_tx_req_valid(m_valid), .m_axis_tx_req_ready(m_ready),
    .s_axis_tx_req_status_len(st_len_i), .s_axis_tx_req_status_tag(st_tag_i),
    .s_axis_tx_req_status_valid(st_valid_i),
    .m_axis_tx_req_status_len(st_len_o), .m_axis_tx_req_status_tag(st_tag_o),
    .m_axis_tx_req_status_valid(st_valid_o),
    .outstanding_count(ocount), .status_error(serr), .byte_count(bcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [QW-1:0] q; logic [MTW-1:0] t; logic [DW-1:0] d; } req_t;
  typedef struct packed { logic [N-1:0] v; logic [TW-1:0] t; logic [LW-1:0] l; } st_t;
  req_t exp_req[$];
  st_t  exp_st[$];

  int n_pass = 0, n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Request-side monitor: every accepted beat must match the next expectation.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_req.size() == 0) begin
        n_total++;
        $display("FAIL req_unexpected: got q=0x%0h tag=0x%0h with nothing expected", m_queue, m_tag);
      end else begin
        req_t e;
        e = exp_req.pop_front();
        chk("req_beat", {m_queue, m_tag, m_dest}, e);
      end
    end
  end

  // Status-side monitor: every forwarded status must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (|st_valid_o)) begin
      if (exp_st.size() == 0) begin
        n_total++;
        $display("FAIL st_unexpected: got valid=0x%0h tag=0x%0h with nothing expected", st_valid_o, st_tag_o);
      end else begin
        st_t e;
        e = exp_st.pop_front();
        chk("st_beat", {st_valid_o, st_tag_o, st_len_o}, e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int s);
    req_t r;
    case (s)
      0:       r = '{q: 8'h10, t: 10'h0A0, d: 5'd1};
      1:       r = '{q: 8'h11, t: 10'h1B1, d: 5'd2};
      default: r = '{q: 8'h12, t: 10'h2C2, d: 5'd3};
    endcase
    exp_req.push_back(r);
  endtask

  task automatic send_status(input logic [MTW-1:0] tag, input logic [LW-1:0] len,
                             input logic [N-1:0] ev, input logic [TW-1:0] et);
    st_t e;
    if (ev != '0) begin
      e = '{v: ev, t: et, l: len};
      exp_st.push_back(e);
    end
    st_tag_i = tag; st_len_i = len; st_valid_i = 1'b1;
    cyc();
    st_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b0; limit = '0; s_valid = '0; m_ready = 1'b0;
    s_queue = {8'h12, 8'h11, 8'h10};
    s_tag   = {8'hC2, 8'hB1, 8'hA0};
    s_dest  = {5'd3, 5'd2, 5'd1};
    st_len_i = '0; st_tag_i = '0; st_valid_i = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_count", ocount, 0);
    chk("rst_err", serr, 0);
    chk("rst_st_valid", st_valid_o, 0);
    chk("rst_bytes", bcount, 0);
    cyc();

    // two schedulers, continuous valid: grants alternate 0,1,0,1
    limit = 6'd4; enable = 1'b1; m_ready = 1'b1; s_valid = 3'b011;
    for (int k = 0; k < 4; k++) begin
      push_req(k % 2);
      @(negedge clk);
      chk("alt_ready", s_ready, 3'b001 << (k % 2));
      cyc();
    end
    s_valid = '0;
    @(negedge clk);
    chk("alt_cnt0", ocount[0 +: OW], 2);
    chk("alt_cnt1", ocount[OW +: OW], 2);
    cyc();
    send_status(10'h0A0, 16'd100, 3'b001, 8'hA0);
    send_status(10'h0A0, 16'd100, 3'b001, 8'hA0);
    send_status(10'h1B1, 16'd200, 3'b010, 8'hB1);
    send_status(10'h1B1, 16'd200, 3'b010, 8'hB1);
    @(negedge clk);
    chk("drain_cnt", ocount, 0);
    cyc();

    // outstanding limit 2 on scheduler 0
    limit = 6'd2; s_valid = 3'b001;
    for (int k = 0; k < 2; k++) begin
      push_req(0);
      @(negedge clk);
      chk("lim_ready", s_ready, 3'b001);
      cyc();
    end
    @(negedge clk);
    chk("lim_block", s_ready, 3'b000);
    chk("lim_cnt", ocount[0 +: OW], 2);
    cyc();
    send_status(10'h005, 16'd10, 3'b001, 8'h05);
    push_req(0);
    @(negedge clk);
    chk("lim_regrant", s_ready, 3'b001);
    cyc();
    @(negedge clk);
    chk("lim_reblock", s_ready, 3'b000);
    cyc();
    s_valid = '0;
    send_status(10'h0A0, 16'd10, 3'b001, 8'hA0);
    send_status(10'h0A0, 16'd10, 3'b001, 8'hA0);
    @(negedge clk);
    chk("lim_drain", ocount, 0);
    cyc();

    // backpressure: held beat stays stable, no further accepts
    limit = 6'd4; m_ready = 1'b0; s_valid = 3'b001;
    push_req(0);
    @(negedge clk);
    chk("hold_first_ready", s_ready, 3'b001);
    cyc();
    s_queue[7:0] = 8'h55;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_ready", s_ready, 3'b000);
      chk("hold_valid", m_valid, 1);
      chk("hold_beat", {m_queue, m_tag, m_dest}, {8'h10, 10'h0A0, 5'd1});
      cyc();
    end
    s_valid = '0; s_queue[7:0] = 8'h10; m_ready = 1'b1;
    cyc();
    send_status(10'h0A0, 16'd1, 3'b001, 8'hA0);

    // enable drop while a beat is held: it still completes, nothing new granted
    m_ready = 1'b0; s_valid = 3'b001;
    push_req(0);
    cyc();
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("en_off_ready", s_ready, 3'b000);
      cyc();
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk("en_off_drain_ready", s_ready, 3'b000);
    cyc();
    @(negedge clk);
    chk("en_off_empty", m_valid, 0);
    cyc();
    s_valid = '0; enable = 1'b1;
    send_status(10'h0A0, 16'd1, 3'b001, 8'hA0);
    @(negedge clk);
    chk("en_drain_cnt", ocount, 0);
    cyc();

    // grant and status on scheduler 1 in the same cycle
    s_valid = 3'b010;
    push_req(1);
    cyc();
    push_req(1);
    begin
      st_t e;
      e = '{v: 3'b010, t: 8'h03, l: 16'd77};
      exp_st.push_back(e);
    end
    st_tag_i = 10'h103; st_len_i = 16'd77; st_valid_i = 1'b1;
    @(negedge clk);
    chk("same_ready", s_ready, 3'b010);
    cyc();
    st_valid_i = 1'b0; s_valid = '0;
    @(negedge clk);
    chk("same_cnt1", ocount[OW +: OW], 1);
    cyc();
    send_status(10'h1B1, 16'd1, 3'b010, 8'hB1);

    // byte totals after a clean reset
    cyc();
    do_reset();
    @(negedge clk);
    chk("rst2_err", serr, 0);
    chk("rst2_bytes", bcount, 0);
    cyc();
    s_valid = 3'b001;
    push_req(0); cyc();
    push_req(0); cyc();
    s_valid = '0;
    cyc();
    send_status(10'h0A0, 16'd1500, 3'b001, 8'hA0);
    send_status(10'h0A0, 16'd64, 3'b001, 8'hA0);
    @(negedge clk);
`ifdef TX_REQ_ARB_BYTE_COUNT_EN
    chk("bytes0", bcount[31:0], 32'd1564);
`else
    chk("bytes0", bcount[31:0], 32'd0);
`endif
    chk("bytes1", bcount[63:32], 0);
    chk("bytes_cnt0", ocount[0 +: OW], 0);
    chk("bytes_err", serr, 0);
    cyc();

    // status to a zero counter: forwarded, count stays 0, error set
    send_status(10'h2C2, 16'd9, 3'b100, 8'hC2);
    @(negedge clk);
    chk("zero_err", serr, 1);
    chk("zero_cnt2", ocount[2*OW +: OW], 0);
    cyc();
    do_reset();
    @(negedge clk);
    chk("rst3_err", serr, 0);
    cyc();

    // status with sel=3 (no such scheduler): dropped, error sticky until reset
    send_status(10'h307, 16'd5, 3'b000, 8'h00);
    @(negedge clk);
    chk("badsel_drop", st_valid_o, 0);
    chk("badsel_err", serr, 1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      chk("badsel_sticky", serr, 1);
    end
    cyc();
    do_reset();
    @(negedge clk);
    chk("rst4_err", serr, 0);
    cyc();

    repeat (3) cyc();
    chk("req_q_empty", exp_req.size(), 0);
    chk("st_q_empty", exp_st.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
